// File: rtl/evp_sched_defs.sv
// Shared opcode, state, status and token-layout definitions for the EVP command scheduler.
// Pure declarations: no latency or backpressure of its own.
package evp_sched_defs;

    typedef enum logic [1:0] {
        OP_STP = 2'b00,
        OP_EVP = 2'b01,
        OP_RST = 2'b10,
        OP_BAD = 2'b11
    } op_t;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_CHECK     = 4'd3,
        ST_LAUNCH    = 4'd4,
        ST_WAIT      = 4'd5,
        ST_WR_RESULT = 4'd6,
        ST_WR_STATUS = 4'd7
    } state_t;

    typedef enum logic [2:0] {
        STS_OK      = 3'd0,
        STS_BAD_N   = 3'd1,
        STS_BAD_OP  = 3'd3,
        STS_TIMEOUT = 3'd4
    } sts_t;

    localparam int OP_W       = 2;
    localparam int A_W        = 3;
    localparam int N_W        = 5;
    localparam int TOK_OP_LSB = 0;
    localparam int TOK_A_LSB  = 2;
    localparam int TOK_N_LSB  = 5;

    function automatic logic [31:0] sts_word(input sts_t s);
        return {29'd0, s};
    endfunction

endpackage

// File: rtl/evp_cmd_scheduler_if.sv
// Scheduler <-> FIFO/engine bundle; master is the scheduler side, slave the FIFOs and engines.
// Wires only: no latency, flow control is carried by the count/free and start/done signals.
interface evp_cmd_scheduler_if #(
    parameter int CNT_W = 11
);
    logic [CNT_W-1:0] cmd_count;
    logic [15:0]      cmd_data;
    logic             cmd_rd_en;
    logic [CNT_W-1:0] data_count;
    logic [CNT_W-1:0] out_free;
    logic             out_wr_en;
    logic [31:0]      out_data;
    logic [2:0]       op_a;
    logic [4:0]       op_n;
    logic             start_stp;
    logic             start_evp;
    logic             start_rst;
    logic             done_stp;
    logic             done_evp;
    logic             done_rst;
    logic [31:0]      evp_result;
    logic [31:0]      evp_status;
    logic             busy;

    modport master (
        input  cmd_count, cmd_data, data_count, out_free,
        input  done_stp, done_evp, done_rst, evp_result, evp_status,
        output cmd_rd_en, out_wr_en, out_data, op_a, op_n,
        output start_stp, start_evp, start_rst, busy
    );

    modport slave (
        output cmd_count, cmd_data, data_count, out_free,
        output done_stp, done_evp, done_rst, evp_result, evp_status,
        input  cmd_rd_en, out_wr_en, out_data, op_a, op_n,
        input  start_stp, start_evp, start_rst, busy
    );
endinterface

// File: rtl/evp_sched_req_check.sv
// Combinational resource gate: ready when the data FIFO and output FIFO can serve the opcode.
// Zero latency; a low ready is the only backpressure, the caller stalls on it.
module evp_sched_req_check
    import evp_sched_defs::*;
#(
    parameter int CNT_W = 11
) (
    input  op_t              i_opcode,
    input  logic [N_W-1:0]   i_n,
    input  logic [CNT_W-1:0] i_data_count,
    input  logic [CNT_W-1:0] i_out_free,
    output logic             o_ready
);

    logic [CNT_W-1:0] w_stp_need;

    // STP consumes N+1 coefficients from the data FIFO
    assign w_stp_need = CNT_W'(i_n) + CNT_W'(1);

    always_comb begin
        o_ready = 1'b0;
        case (i_opcode)
            OP_STP:  o_ready = (i_data_count >= w_stp_need) && (i_out_free >= CNT_W'(1));
            OP_EVP:  o_ready = (i_data_count >= CNT_W'(1)) && (i_out_free >= CNT_W'(2));
            OP_RST:  o_ready = (i_out_free >= CNT_W'(1));
            default: o_ready = 1'b0;
        endcase
    end

endmodule

// File: rtl/evp_cmd_scheduler.sv
// One-command-at-a-time STP/EVP/RST scheduler, >=6 cycles IDLE->IDLE plus engine time; stalls in CHECK on FIFO levels.
// Optional WAIT watchdog under EVP_SCHED_TIMEOUT_EN (status 4 after TIMEOUT_CYCLES).
module evp_cmd_scheduler
    import evp_sched_defs::*;
#(
    parameter int BUFFER_SIZE    = 1024,
    parameter int CNT_W          = 11,
    parameter int MAX_N          = 10,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst,
    evp_cmd_scheduler_if.master bus
);

    if (CNT_W != $clog2(BUFFER_SIZE) + 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_cfg_err
        $error("evp_cmd_scheduler: inconsistent CNT_W/BUFFER_SIZE/TIMEOUT_CYCLES");
    end

    localparam logic [N_W-1:0] L_MAX_N = N_W'(MAX_N);

    state_t           r_state;
    op_t              r_opcode;
    logic [A_W-1:0]   r_op_a;
    logic [N_W-1:0]   r_op_n;
    logic             r_cmd_rd_en;
    logic             r_out_wr_en;
    logic [31:0]      r_out_data;
    logic             r_start_stp;
    logic             r_start_evp;
    logic             r_start_rst;
    logic             r_busy;
    logic [31:0]      r_status;
`ifdef EVP_SCHED_TIMEOUT_EN
    localparam logic [15:0] L_WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]      r_wd_cnt;
`endif

    op_t              w_tok_op;
    logic [A_W-1:0]   w_tok_a;
    logic [N_W-1:0]   w_tok_n;
    logic             w_ready;
    logic             w_done;
    logic             w_unused;

    assign w_tok_op = op_t'(bus.cmd_data[TOK_OP_LSB +: OP_W]);
    assign w_tok_a  = bus.cmd_data[TOK_A_LSB +: A_W];
    assign w_tok_n  = bus.cmd_data[TOK_N_LSB +: N_W];
    assign w_unused = &{1'b0, bus.cmd_data[15:10]};

    evp_sched_req_check #(
        .CNT_W (CNT_W)
    ) u_req_check (
        .i_opcode     (r_opcode),
        .i_n          (r_op_n),
        .i_data_count (bus.data_count),
        .i_out_free   (bus.out_free),
        .o_ready      (w_ready)
    );

    // Only the engine that was launched can complete the command
    always_comb begin
        w_done = 1'b0;
        case (r_opcode)
            OP_STP:  w_done = bus.done_stp;
            OP_EVP:  w_done = bus.done_evp;
            OP_RST:  w_done = bus.done_rst;
            default: w_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_opcode    <= OP_STP;
            r_op_a      <= '0;
            r_op_n      <= '0;
            r_cmd_rd_en <= 1'b0;
            r_out_wr_en <= 1'b0;
            r_out_data  <= '0;
            r_start_stp <= 1'b0;
            r_start_evp <= 1'b0;
            r_start_rst <= 1'b0;
            r_busy      <= 1'b0;
            r_status    <= '0;
`ifdef EVP_SCHED_TIMEOUT_EN
            r_wd_cnt    <= '0;
`endif
        end else begin
            r_cmd_rd_en <= 1'b0;
            r_out_wr_en <= 1'b0;
            r_start_stp <= 1'b0;
            r_start_evp <= 1'b0;
            r_start_rst <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_count != '0) begin
                        r_cmd_rd_en <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_FETCH;
                    end
                end
                ST_FETCH: r_state <= ST_DECODE;
                ST_DECODE: begin
                    r_opcode <= w_tok_op;
                    r_op_a   <= w_tok_a;
                    r_op_n   <= w_tok_n;
                    if (w_tok_op == OP_BAD) begin
                        r_status    <= sts_word(STS_BAD_OP);
                        r_out_wr_en <= 1'b1;
                        r_out_data  <= sts_word(STS_BAD_OP);
                        r_state     <= ST_WR_STATUS;
                    end else if (w_tok_op == OP_STP && w_tok_n > L_MAX_N) begin
                        r_status    <= sts_word(STS_BAD_N);
                        r_out_wr_en <= 1'b1;
                        r_out_data  <= sts_word(STS_BAD_N);
                        r_state     <= ST_WR_STATUS;
                    end else begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_ready) begin
                        r_start_stp <= (r_opcode == OP_STP);
                        r_start_evp <= (r_opcode == OP_EVP);
                        r_start_rst <= (r_opcode == OP_RST);
                        r_state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
`ifdef EVP_SCHED_TIMEOUT_EN
                    r_wd_cnt <= '0;
`endif
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_done) begin
                        r_out_wr_en <= 1'b1;
                        if (r_opcode == OP_EVP) begin
                            r_status <= bus.evp_status;
                            // A failed evaluation reports its status only
                            if (bus.evp_status == '0) begin
                                r_out_data <= bus.evp_result;
                                r_state    <= ST_WR_RESULT;
                            end else begin
                                r_out_data <= bus.evp_status;
                                r_state    <= ST_WR_STATUS;
                            end
                        end else begin
                            r_status   <= sts_word(STS_OK);
                            r_out_data <= sts_word(STS_OK);
                            r_state    <= ST_WR_STATUS;
                        end
                    end
`ifdef EVP_SCHED_TIMEOUT_EN
                    else if (r_wd_cnt == L_WD_LAST) begin
                        r_status    <= sts_word(STS_TIMEOUT);
                        r_out_wr_en <= 1'b1;
                        r_out_data  <= sts_word(STS_TIMEOUT);
                        r_state     <= ST_WR_STATUS;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 16'd1;
                    end
`endif
                end
                ST_WR_RESULT: begin
                    r_out_wr_en <= 1'b1;
                    r_out_data  <= r_status;
                    r_state     <= ST_WR_STATUS;
                end
                ST_WR_STATUS: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_rd_en = r_cmd_rd_en;
    assign bus.out_wr_en = r_out_wr_en;
    assign bus.out_data  = r_out_data;
    assign bus.op_a      = r_op_a;
    assign bus.op_n      = r_op_n;
    assign bus.start_stp = r_start_stp;
    assign bus.start_evp = r_start_evp;
    assign bus.start_rst = r_start_rst;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_evp_cmd_scheduler.sv
// Directed bench for evp_cmd_scheduler with command-FIFO model and output-token scoreboard.
module tb_evp_cmd_scheduler;

    localparam int CNT_W = 11;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    evp_cmd_scheduler_if #(.CNT_W(CNT_W)) bus ();

    evp_cmd_scheduler #(
        .BUFFER_SIZE    (1024),
        .CNT_W          (CNT_W),
        .MAX_N          (10),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int n_stp       = 0;
    int n_evp       = 0;
    int n_rst       = 0;
    logic [15:0] cmd_q[$];
    logic [31:0] sb[$];
    int          wr_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Command FIFO model, start-pulse counters and output scoreboard
    always @(negedge clk) begin
        if (bus.start_stp) n_stp++;
        if (bus.start_evp) n_evp++;
        if (bus.start_rst) n_rst++;
        if (bus.cmd_rd_en) begin
            chk("rd_en_nonempty", 32'(bus.cmd_count != '0), 32'd1);
            if (cmd_q.size() > 0) bus.cmd_data = cmd_q.pop_front();
        end
        bus.cmd_count = CNT_W'(cmd_q.size());
        if (bus.out_wr_en) begin
            wr_cyc.push_back(cyc);
            chk("wr_space", 32'(bus.out_free != '0), 32'd1);
            chk("wr_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) chk("out_token", bus.out_data, sb.pop_front());
        end
    end

    task automatic wait_start(input string tag, input int which, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = (which == 0) ? bus.start_stp : (which == 1) ? bus.start_evp : bus.start_rst;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int i = 0;
        while (sb.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic pulse_done(input int which, input logic [31:0] res, input logic [31:0] sts);
        @(negedge clk);
        bus.evp_result = res;
        bus.evp_status = sts;
        case (which)
            0:       bus.done_stp = 1'b1;
            1:       bus.done_evp = 1'b1;
            default: bus.done_rst = 1'b1;
        endcase
        @(negedge clk);
        bus.done_stp = 1'b0;
        bus.done_evp = 1'b0;
        bus.done_rst = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctl"}, 32'({bus.cmd_rd_en, bus.out_wr_en, bus.busy,
                                bus.start_stp, bus.start_evp, bus.start_rst}), 32'd0);
        chk({tag, "_data"}, bus.out_data, 32'd0);
        chk({tag, "_ops"}, 32'({bus.op_a, bus.op_n}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int evp_base;
        rst            = 1'b0;
        bus.data_count = '0;
        bus.out_free   = CNT_W'(1024);
        bus.done_stp   = 1'b0;
        bus.done_evp   = 1'b0;
        bus.done_rst   = 1'b0;
        bus.evp_result = '0;
        bus.evp_status = '0;
        // EVP A=1, STP A=2 N=3, STP N=12, bad opcode, EVP A=1
        cmd_q = {16'h0005, 16'h0068, 16'h0180, 16'h0003, 16'h0005};

        // Reset with five commands pending
        repeat (4) @(negedge clk);
        chk_outputs_zero("reset");

        // EVP success: result then status on consecutive writes
        bus.data_count = CNT_W'(1);
        bus.out_free   = CNT_W'(2);
        sb.push_back(32'd57);
        sb.push_back(32'd0);
        rst = 1'b1;
        wait_start("evp1_start", 1, 20);
        chk("evp1_op_a", 32'(bus.op_a), 32'd1);
        repeat (19) @(negedge clk);
        pulse_done(1, 32'd57, 32'd0);
        bus.data_count = CNT_W'(2);
        bus.out_free   = CNT_W'(1024);
        wait_drain("evp1_drain", 10);
        chk("evp1_start_cnt", 32'(n_evp), 32'd1);
        chk("evp1_back2back", 32'(wr_cyc[1] - wr_cyc[0]), 32'd1);

        // STP N=3 stalls with only two data tokens
        repeat (12) @(negedge clk);
        chk("stp_stall_nostart", 32'(n_stp), 32'd0);
        chk("stp_stall_busy", 32'(bus.busy), 32'd1);
        chk("stp_op_a", 32'(bus.op_a), 32'd2);
        chk("stp_op_n", 32'(bus.op_n), 32'd3);
        sb.push_back(32'd0);
        bus.data_count = CNT_W'(4);
        wait_start("stp_start", 0, 10);
        bus.done_stp = 1'b1;
        @(negedge clk);
        bus.done_stp = 1'b0;
        repeat (3) @(negedge clk);
        chk("stp_launch_done_ignored", 32'(sb.size()), 32'd1);
        pulse_done(2, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        chk("stp_foreign_done_ignored", 32'(sb.size()), 32'd1);
        pulse_done(0, 32'd0, 32'd0);
        wait_drain("stp_drain", 10);
        chk("stp_start_cnt", 32'(n_stp), 32'd1);

        // STP with N above MAX_N
        sb.push_back(32'd1);
        wait_drain("badn_drain", 20);
        chk("badn_no_start", 32'(n_stp + n_evp + n_rst), 32'd2);
        chk("badn_op_n", 32'(bus.op_n), 32'd12);

        // Invalid opcode, then EVP stalls on a single free output slot
        bus.out_free = CNT_W'(1);
        sb.push_back(32'd3);
        wait_drain("badop_drain", 20);
        repeat (10) @(negedge clk);
        chk("evp2_stall_nostart", 32'(n_evp), 32'd1);
        chk("evp2_stall_busy", 32'(bus.busy), 32'd1);
        sb.push_back(32'd7);
        bus.out_free = CNT_W'(2);
        wait_start("evp2_start", 1, 10);
        pulse_done(1, 32'hDEAD_BEEF, 32'd7);
        wait_drain("evp2_drain", 10);
        repeat (3) @(negedge clk);
        chk("total_writes", 32'(wr_cyc.size()), 32'd6);

        // RST A=5 ignores a stray EVP completion
        sb.push_back(32'd0);
        cmd_q.push_back(16'h0016);
        wait_start("rst_start", 2, 15);
        chk("rst_op_a", 32'(bus.op_a), 32'd5);
        pulse_done(1, 32'd5, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_foreign_done_ignored", 32'(sb.size()), 32'd1);
        pulse_done(2, 32'd0, 32'd0);
        wait_drain("rst_drain", 10);
        chk("rst_start_cnt", 32'(n_rst), 32'd1);

`ifdef EVP_SCHED_TIMEOUT_EN
        begin
            int t0;
            sb.push_back(32'd4);
            cmd_q.push_back(16'h0005);
            wait_start("to_start", 1, 15);
            t0 = cyc;
            wait_drain("to_drain", 40);
            chk("to_latency", 32'(wr_cyc[wr_cyc.size() - 1] - t0), 32'd17);
            repeat (3) @(negedge clk);
            pulse_done(1, 32'd9, 32'd0);
            repeat (5) @(negedge clk);
            chk("to_stray_done_idle", 32'(bus.busy), 32'd0);
        end
`endif

        // Reset while an EVP is waiting for its engine
        evp_base = n_evp;
        cmd_q.push_back(16'h0005);
        wait_start("rstwait_start", 1, 15);
        repeat (3) @(negedge clk);
        chk("rstwait_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        #1;
        chk_outputs_zero("rstwait");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("rstwait_idle", 32'(bus.busy), 32'd0);
        chk("rstwait_start_cnt", 32'(n_evp - evp_base), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
